line_buffer_ctrl: RTL and testbench
===================================

# line_buffer_ctrl

Sequencing controller for the Sobel line-buffer bank. Strobes write enables into four `fifo_single_line_buffer` instances in rotation and reads the three completed lines in parallel. Flags each valid 3-row column for the Sobel kernel and drains the final window set at end of frame. Pixel data fans out to all buffers externally; this block issues controls only.

## Interface
- `LINE_W`, 512, pixels per line; must be ≥2.
- `IMG_H`, 512, lines per frame; must be ≥4; otherwise elaboration error.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pix_valid_i`  in  1  incoming pixel valid.
- `pix_ready_o`  out  1  controller accepts a pixel; handshake = `pix_valid_i && pix_ready_o`.
- `buf_we_o`  out  4  one-hot write enable, bit k drives `we_i` of buffer k.
- `buf_rd_o`  out  4  read enables; three bits set when reading.
- `win_sel_o`  out  2  index of buffer holding the window's top row.
- `win_valid_o`  out  1  three-row column valid at buffer outputs.
- `frame_done_o`  out  1  one-cycle end-of-frame pulse.
- `stall_cnt_o`  out  16  present only with `LBC_STALL_CNT_EN`.

## Operation
- States: IDLE, FILL, RUN, DRAIN, DONE.
- Counters: `col` 0..LINE_W-1, `row` 0..IMG_H-1, `wr_ptr` 0..3 (mod 4).
- `pix_ready_o` is 1 in IDLE, FILL and RUN, and 0 in DRAIN and DONE. It is combinational from state.
- On each handshake:
  - Assert `buf_we_o = 1<<wr_ptr` combinationally and increment `col`.
  - At `col==LINE_W-1`: wrap `col` to 0, increment `row`, and rotate `wr_ptr` in the same cycle.
- IDLE→FILL on the first handshake. That pixel is written to buffer 0.
- FILL→RUN when line 2 completes (after 3·LINE_W pixels).
- In RUN, each handshake also asserts `buf_rd_o = ~(1<<wr_ptr)`.
- RUN→DRAIN when line IMG_H-1 completes.
- In DRAIN:
  - Issue LINE_W internal reads, one per cycle.
  - `buf_rd_o = ~(1<<wr_ptr)`, using the post-rotation `wr_ptr`.
  - No writes.
- DRAIN→DONE after the last read. DONE pulses `frame_done_o` for one cycle, then returns to IDLE. `wr_ptr`, `col` and `row` are cleared.
- Top-row pointer is `(wr_ptr+1) mod 4` at read time.
- No handshake (bubble): no enables, counters hold, state holds.
- Windows per frame: exactly (IMG_H-2)·LINE_W.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - `buf_we_o=0`, `buf_rd_o=0`, `win_valid_o=0`, `win_sel_o=0`, `frame_done_o=0`, `stall_cnt_o=0`.
  - `pix_ready_o=1`.
- `buf_we_o` and `buf_rd_o` are asserted in the handshake cycle.
- `win_valid_o` and `win_sel_o` are registered one cycle after each read, matching the 1-cycle buffer read latency.
- Line-wrap cycle: the last pixel of a line is written using the old `wr_ptr`; the next cycle uses the new one.
- DRAIN lasts exactly LINE_W cycles. `frame_done_o` comes one cycle after the last DRAIN read, coincident with the final `win_valid_o`.
- `rst` in any state: next cycle is IDLE with reset values. In-flight `win_valid_o` is dropped. Buffers share `rst`.
- `pix_valid_i` high during DRAIN or DONE is ignored. It is held off by `pix_ready_o=0`.

## Configuration
- Macro `LBC_STALL_CNT_EN`.
- Defined:
  - `stall_cnt_o` counts cycles in FILL or RUN with `pix_valid_i=0`.
  - Saturates at 16'hFFFF.
  - Clears on IDLE→FILL and on reset.
  - Holds its value through DRAIN, DONE and IDLE.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `lbc_pkg` holds:
  - The state enum.
  - `NUM_BUF=4` and `PTR_W=2`.
  - The stall counter width (16).
- Sub-module `line_pos_counter` handles col/row counting with wrap and last-pixel flags, parameterised by LINE_W and IMG_H. The top level contains the FSM, pointer and output registers.

## Test plan
(Use LINE_W=8, IMG_H=5.)
- **Reset:** `rst=1` for 2 cycles → all outputs 0 except `pix_ready_o=1`; no enables for 3 further idle cycles.
- **Continuous stream of 40 pixels:**
  - `buf_we_o` = 0001 for px 0–7, 0010 for 8–15, 0100 for 16–23, 1000 for 24–31, 0001 for 32–39.
  - px 24–31: `buf_rd_o=0111`, then `win_sel_o=0`.
  - px 32–39: `buf_rd_o=1110`, then `win_sel_o=1`.
- **Drain:**
  - After px 39, `pix_ready_o=0` for 9 cycles, with `buf_rd_o=1101` for 8 cycles and `win_sel_o=2`.
  - `frame_done_o` pulses once.
  - Total `win_valid_o` count = 24.
- **Bubbles:** `pix_valid_i` alternating 1/0 for the whole frame → enables only on valid cycles; still 24 windows and one `frame_done_o`.
- **Mid-frame reset:** `rst` at px 20 → next cycle IDLE with zero outputs. The next frame's px 0 writes buffer 0, and the full 24-window frame completes.
- **`LBC_STALL_CNT_EN`:** 16 pixels with one idle cycle between each → `stall_cnt_o=15`. It holds at 15 while `pix_valid_i=0`, and clears at the next frame start.

Source files
------------

// File: rtl/line_buffer_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lbc_pkg : states, widths and helpers for line_buffer_ctrl  Rev 1.0 |
// +--------------------------------------------------------------------+
package lbc_pkg;

  localparam int NUM_BUF = 4;
  localparam int PTR_W   = 2;
  localparam int STALL_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [NUM_BUF-1:0] buf_onehot(input logic [PTR_W-1:0] ptr);
    return {{(NUM_BUF-1){1'b0}}, 1'b1} << ptr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buffer_ctrl_if : pixel handshake and buffer controls  Rev 1.0 |
// +--------------------------------------------------------------------+
interface line_buffer_ctrl_if;
  import lbc_pkg::*;

  logic               pix_valid_i;
  logic               pix_ready_o;
  logic [NUM_BUF-1:0] buf_we_o;
  logic [NUM_BUF-1:0] buf_rd_o;
  logic [PTR_W-1:0]   win_sel_o;
  logic               win_valid_o;
  logic               frame_done_o;
`ifdef LBC_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt_o;
`endif

  modport master (
    input  pix_valid_i,
`ifdef LBC_STALL_CNT_EN
    output stall_cnt_o,
`endif
    output pix_ready_o,
    output buf_we_o,
    output buf_rd_o,
    output win_sel_o,
    output win_valid_o,
    output frame_done_o
  );

  modport slave (
    output pix_valid_i,
`ifdef LBC_STALL_CNT_EN
    input  stall_cnt_o,
`endif
    input  pix_ready_o,
    input  buf_we_o,
    input  buf_rd_o,
    input  win_sel_o,
    input  win_valid_o,
    input  frame_done_o
  );

endinterface
`default_nettype wire

// File: rtl/line_buffer_ctrl_line_pos_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_pos_counter : column/row position with wrap flags     Rev 1.0 |
// +--------------------------------------------------------------------+
module line_pos_counter #(
  parameter  int LINE_W = 512,
  parameter  int IMG_H  = 512,
  localparam int ROW_W  = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic             col_last,
  output logic             row_last
);

  localparam int COL_W = $clog2(LINE_W);

  logic [COL_W-1:0] col;

  assign col_last = (col == COL_W'(LINE_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buffer_ctrl : Sobel line-buffer sequencer; optional macro     |
// | LBC_STALL_CNT_EN adds the stall_cnt_o counter.             Rev 1.0 |
// +--------------------------------------------------------------------+
module line_buffer_ctrl #(
  parameter int LINE_W = 512,
  parameter int IMG_H  = 512
) (
  input  logic               clk,
  input  logic               rst,
  line_buffer_ctrl_if.master bus
);
  import lbc_pkg::*;

  localparam int ROW_W = $clog2(IMG_H);

  if (LINE_W < 2 || IMG_H < 4) begin : g_param_check
    $error("line_buffer_ctrl: LINE_W must be >= 2 and IMG_H >= 4");
  end

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [NUM_BUF-1:0] buf_we;
  logic [NUM_BUF-1:0] buf_rd;
  logic               rd_issue;
  logic               pos_adv;
  logic               pos_clear;
  logic               pix_ready;
  logic               hs;
  logic               win_valid;
  logic [PTR_W-1:0]   win_sel;
  logic [ROW_W-1:0]   row;
  logic               col_last;
  logic               row_last;

  line_pos_counter #(
    .LINE_W (LINE_W),
    .IMG_H  (IMG_H)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clear    (pos_clear),
    .advance  (pos_adv),
    .row      (row),
    .col_last (col_last),
    .row_last (row_last)
  );

  assign pix_ready = (state == ST_IDLE) || (state == ST_FILL) || (state == ST_RUN);
  assign hs        = bus.pix_valid_i && pix_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    buf_we    = '0;
    buf_rd    = '0;
    rd_issue  = 1'b0;
    pos_adv   = 1'b0;
    pos_clear = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (hs) begin
          buf_we    = buf_onehot(wr_ptr);
          pos_adv   = 1'b1;
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (hs) begin
          buf_we  = buf_onehot(wr_ptr);
          pos_adv = 1'b1;
          // Three full lines are buffered once line 2 completes.
          if (col_last && row == ROW_W'(2)) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (hs) begin
          buf_we   = buf_onehot(wr_ptr);
          buf_rd   = ~buf_onehot(wr_ptr);
          rd_issue = 1'b1;
          pos_adv  = 1'b1;
          if (col_last && row_last) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The column counter doubles as the drain read counter.
        buf_rd   = ~buf_onehot(wr_ptr);
        rd_issue = 1'b1;
        pos_adv  = 1'b1;
        if (col_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        pos_clear = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      win_valid <= 1'b0;
      win_sel   <= '0;
    end else begin
      if (state == ST_DONE)    wr_ptr <= '0;
      else if (hs && col_last) wr_ptr <= wr_ptr + 1'b1;
      win_valid <= rd_issue;
      if (rd_issue) win_sel <= wr_ptr + 1'b1;
    end
  end

`ifdef LBC_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && hs) begin
      stall_cnt <= '0;
    end else if ((state == ST_FILL || state == ST_RUN) && !bus.pix_valid_i &&
                 stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
`endif

  assign bus.pix_ready_o  = pix_ready;
  assign bus.buf_we_o     = buf_we;
  assign bus.buf_rd_o     = buf_rd;
  assign bus.win_valid_o  = win_valid;
  assign bus.win_sel_o    = win_sel;
  assign bus.frame_done_o = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_line_buffer_ctrl : randomized bench with frame-level model Rev 1.0 |
// +--------------------------------------------------------------------+
module tb_line_buffer_ctrl;

  localparam int W = 8;
  localparam int H = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model: pixels accepted this frame, drain cycles elapsed.
  int         m_n;
  int         m_d;
  int         m_frames;
  logic       m_wv;
  logic [1:0] m_sel;
  int         win_cnt;
  int         done_cnt;
`ifdef LBC_STALL_CNT_EN
  int         m_stall;
`endif

  line_buffer_ctrl_if bus ();

  line_buffer_ctrl #(
    .LINE_W (W),
    .IMG_H  (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_cycle(input logic r, input logic v);
    logic [3:0] e_we;
    logic [3:0] e_rd;
    logic       e_ready;
    logic       e_done;
    logic       hs;
    logic [1:0] sel_now;
    int         line;
`ifdef LBC_STALL_CNT_EN
    logic       in_fill_run;
`endif
    @(negedge clk);
    rst             = r;
    bus.pix_valid_i = v;
    #1;
    e_we    = '0;
    e_rd    = '0;
    e_ready = 1'b0;
    e_done  = 1'b0;
    hs      = 1'b0;
    sel_now = m_sel;
    if (m_n < H * W) begin
      e_ready = 1'b1;
      if (v) begin
        line = m_n / W;
        hs   = 1'b1;
        e_we = 4'b0001 << (line % 4);
        if (line >= 3) begin
          e_rd    = ~e_we;
          sel_now = 2'((line + 1) % 4);
        end
      end
    end else if (m_d < W) begin
      e_rd    = ~(4'b0001 << (H % 4));
      sel_now = 2'((H + 1) % 4);
    end else begin
      e_done = 1'b1;
    end
`ifdef LBC_STALL_CNT_EN
    in_fill_run = (m_n > 0) && (m_n < H * W);
`endif
    if (!r) begin
      check_val("pix_ready", 32'(bus.pix_ready_o), 32'(e_ready));
      check_val("buf_we", 32'(bus.buf_we_o), 32'(e_we));
      check_val("buf_rd", 32'(bus.buf_rd_o), 32'(e_rd));
      check_val("win_valid", 32'(bus.win_valid_o), 32'(m_wv));
      check_val("win_sel", 32'(bus.win_sel_o), 32'(m_sel));
      check_val("frame_done", 32'(bus.frame_done_o), 32'(e_done));
`ifdef LBC_STALL_CNT_EN
      check_val("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_stall));
`endif
      if (bus.win_valid_o) win_cnt++;
      if (bus.frame_done_o) done_cnt++;
      if (e_done) begin
        check_val("frame_windows", 32'(win_cnt), 32'((H - 2) * W));
        check_val("frame_done_pulses", 32'(done_cnt), 32'd1);
        win_cnt  = 0;
        done_cnt = 0;
      end
    end
    @(posedge clk);
    if (r) begin
      m_n      = 0;
      m_d      = 0;
      m_wv     = 1'b0;
      m_sel    = '0;
      win_cnt  = 0;
      done_cnt = 0;
`ifdef LBC_STALL_CNT_EN
      m_stall  = 0;
`endif
    end else begin
`ifdef LBC_STALL_CNT_EN
      if (m_n == 0 && hs) m_stall = 0;
      else if (in_fill_run && !v && m_stall < 65535) m_stall++;
`endif
      m_wv = (e_rd != 4'b0000);
      if (e_rd != 4'b0000) m_sel = sel_now;
      if (hs) begin
        m_n++;
      end else if (m_n == H * W) begin
        if (m_d < W) m_d++;
        else begin
          m_n = 0;
          m_d = 0;
          m_frames++;
        end
      end
    end
  endtask

  // mode 0: continuous, 1: alternating 1/0, otherwise random at pct%.
  task automatic run_frames(input int nfr, input int mode, input int pct);
    int   target;
    int   cyc;
    logic v;
    target = m_frames + nfr;
    cyc    = 0;
    while (m_frames < target && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 99) < pct);
      endcase
      run_cycle(1'b0, v);
      cyc++;
    end
    if (m_frames < target) check_val("frame_timeout", 32'(m_frames), 32'(target));
  endtask

  initial begin
    int guard;
    checks   = 0;
    errors   = 0;
    m_n      = 0;
    m_d      = 0;
    m_frames = 0;
    m_wv     = 1'b0;
    m_sel    = '0;
    win_cnt  = 0;
    done_cnt = 0;
`ifdef LBC_STALL_CNT_EN
    m_stall  = 0;
`endif
    rst             = 1'b1;
    bus.pix_valid_i = 1'b0;

    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0);

    run_frames(1, 0, 100);
    run_frames(1, 1, 0);

    guard = 0;
    while (m_n < 20 && guard < 100) begin
      run_cycle(1'b0, 1'b1);
      guard++;
    end
    check_val("reached_px20", 32'(m_n), 32'd20);
    run_cycle(1'b1, 1'b1);
    run_cycle(1'b0, 1'b0);
    run_frames(1, 2, 70);

    for (int f = 0; f < 4; f++) run_frames(1, 2, 20 + 20 * f);

    for (int i = 0; i < 7; i++) run_cycle(1'b0, $urandom_range(0, 1) == 1);
    run_frames(1, 2, 50);

`ifdef LBC_STALL_CNT_EN
    for (int i = 0; i < 16; i++) begin
      run_cycle(1'b0, 1'b1);
      if (i < 15) run_cycle(1'b0, 1'b0);
    end
    #2 check_val("stall_after_16px", 32'(bus.stall_cnt_o), 32'd15);
    run_frames(1, 0, 100);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0);
    #2 check_val("stall_hold_idle", 32'(bus.stall_cnt_o), 32'd15);
    run_cycle(1'b0, 1'b1);
    #2 check_val("stall_clear_start", 32'(bus.stall_cnt_o), 32'd0);
    run_frames(1, 0, 100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
